// File: rtl/moving_avg_filter_pkg.sv
// ----------------------------------------------------------------------------
// moving_avg_filter_pkg
// Shared definitions for the moving-average filter:
//   state_t      - FSM encoding (ST_FILL while the window is filling, ST_RUN after)
//   acc_width()  - width of the full-precision window accumulator
//   round_const()- half-LSB offset added before the divide-by-N shift
// ----------------------------------------------------------------------------
package moving_avg_filter_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Sum of N = 2^log2_n samples of data_w bits needs log2_n extra bits.
  function automatic int acc_width(input int data_w, input int log2_n);
    return data_w + log2_n;
  endfunction

  // Round-half-up offset; zero when truncating or when there is no shift.
  function automatic int round_const(input int log2_n, input int round_en);
    if (round_en != 0 && log2_n > 0) begin
      return 1 << (log2_n - 1);
    end
    return 0;
  endfunction

endpackage

// File: rtl/avg_window_ram.sv
// ----------------------------------------------------------------------------
// avg_window_ram
// Circular sample store for the moving-average window. Synchronous write,
// combinational read at the same address, so the entry about to be
// overwritten (the oldest sample) is visible during the write cycle.
// No reset: contents are ignored until the window has been filled once.
// Ports:
//   i_clk   - clock
//   i_we    - write enable
//   i_addr  - read/write address (the window write pointer)
//   i_wdata - sample to store
//   o_rdata - current contents at i_addr
// ----------------------------------------------------------------------------
module avg_window_ram #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/moving_avg_filter.sv
// ----------------------------------------------------------------------------
// moving_avg_filter
// Running mean of the last N = 2^LOG2_N accepted signed samples, computed
// with a full-precision accumulator (add newest, subtract oldest) and an
// optional round-half-up before the arithmetic divide-by-N shift.
// Ports:
//   CLK       - clock, all state changes on the rising edge
//   RST       - asynchronous active-high reset
//   IN        - signed input sample (DATA_W bits)
//   IN_VALID  - IN accepted on a rising edge when high
//   CLEAR     - synchronous window flush; a sample presented with it is dropped
//   OUT       - signed registered average
//   OUT_VALID - one-cycle pulse marking a new OUT
//   PRIMED    - high while the window holds N samples
// ----------------------------------------------------------------------------
module moving_avg_filter
  import moving_avg_filter_pkg::*;
#(
  parameter int DATA_W    = 24,
  parameter int LOG2_N    = 4,
  parameter int ROUND     = 1,
  parameter int EARLY_OUT = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] IN,
  input  logic              IN_VALID,
  input  logic              CLEAR,
  output logic [DATA_W-1:0] OUT,
  output logic              OUT_VALID,
  output logic              PRIMED
);

  localparam int N     = 1 << LOG2_N;
  // A zero-bit pointer is not expressible; with N = 1 the single bit stays 0.
  localparam int PTR_W = (LOG2_N > 0) ? LOG2_N : 1;
  localparam int ACC_W = acc_width(DATA_W, LOG2_N);
  localparam int SUM_W = ACC_W + 1;
  localparam logic signed [SUM_W-1:0] RND = SUM_W'(round_const(LOG2_N, ROUND));
  localparam bit EARLY = (EARLY_OUT != 0);

  state_t r_state, w_state_next;

  logic signed [ACC_W-1:0]  r_acc;
  logic [PTR_W-1:0]         r_ptr;
  logic [DATA_W-1:0]        r_out;
  logic                     r_out_valid;

  logic                     w_accept;
  logic                     w_last_fill;
  logic                     w_emit;
  logic [PTR_W-1:0]         w_ptr_next;
  logic [DATA_W-1:0]        w_ram_rd;
  logic signed [DATA_W-1:0] w_in;
  logic signed [DATA_W-1:0] w_oldest;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic signed [SUM_W-1:0]  w_sum;
  logic signed [DATA_W-1:0] w_avg;

  // CLEAR wins over IN_VALID: the sample is discarded.
  assign w_accept    = IN_VALID && !CLEAR;
  assign w_ptr_next  = (r_ptr == PTR_W'(N - 1)) ? '0 : r_ptr + 1'b1;
  // While filling, the write pointer starts at 0 and advances once per
  // accepted sample, so it doubles as the fill count.
  assign w_last_fill = (r_state == ST_FILL) && (r_ptr == PTR_W'(N - 1));
  assign w_emit      = (r_state == ST_RUN) || w_last_fill || EARLY;

  avg_window_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (PTR_W),
    .DEPTH  (N)
  ) u_ram (
    .i_clk   (CLK),
    .i_we    (w_accept),
    .i_addr  (r_ptr),
    .i_wdata (IN),
    .o_rdata (w_ram_rd)
  );

  // Buffer contents are unknown until the window has been filled, so the
  // oldest sample is treated as zero in FILL.
  assign w_in       = IN;
  assign w_oldest   = (r_state == ST_RUN) ? w_ram_rd : '0;
  assign w_acc_next = r_acc + ACC_W'(w_in) - ACC_W'(w_oldest);
  // One guard bit so adding the rounding offset cannot overflow.
  assign w_sum      = SUM_W'(w_acc_next) + RND;
  assign w_avg      = DATA_W'(w_sum >>> LOG2_N);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_FILL: if (w_accept && w_last_fill) w_state_next = ST_RUN;
      ST_RUN:  w_state_next = ST_RUN;
      default: w_state_next = ST_FILL;
    endcase
    if (CLEAR) begin
      w_state_next = ST_FILL;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_acc       <= '0;
      r_ptr       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (CLEAR) begin
        r_acc <= '0;
        r_ptr <= '0;
      end else if (w_accept) begin
        r_acc <= w_acc_next;
        r_ptr <= w_ptr_next;
        if (w_emit) begin
          r_out       <= w_avg;
          r_out_valid <= 1'b1;
        end
      end
    end
  end

  assign OUT       = r_out;
  assign OUT_VALID = r_out_valid;
  assign PRIMED    = (r_state == ST_RUN);

endmodule

// File: tb/tb_moving_avg_filter.sv
// ----------------------------------------------------------------------------
// tb_moving_avg_filter
// Three filters share one stimulus stream:
//   dut_a: N=4, round half up, results only once primed
//   dut_b: N=4, truncate, results while filling too
//   dut_c: N=1, straight pass-through with one cycle latency
// The stimulus pushes hand-computed expected averages into per-DUT queues;
// a monitor pops them whenever OUT_VALID is seen and also flags OUT moving
// without OUT_VALID.
// ----------------------------------------------------------------------------
module tb_moving_avg_filter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CLEAR = 1'b0;
  logic        IN_VALID = 1'b0;
  logic [23:0] IN = '0;

  logic [23:0] out_a, out_b, out_c;
  logic        vld_a, vld_b, vld_c;
  logic        prm_a, prm_b, prm_c;

  int n_cmp = 0;
  int n_bad = 0;

  logic [23:0] q_a[$];
  logic [23:0] q_b[$];
  logic [23:0] q_c[$];

  always #5 CLK = ~CLK;

  moving_avg_filter #(.DATA_W(24), .LOG2_N(2), .ROUND(1), .EARLY_OUT(0)) dut_a (
    .CLK(CLK), .RST(RST), .IN(IN), .IN_VALID(IN_VALID), .CLEAR(CLEAR),
    .OUT(out_a), .OUT_VALID(vld_a), .PRIMED(prm_a));

  moving_avg_filter #(.DATA_W(24), .LOG2_N(2), .ROUND(0), .EARLY_OUT(1)) dut_b (
    .CLK(CLK), .RST(RST), .IN(IN), .IN_VALID(IN_VALID), .CLEAR(CLEAR),
    .OUT(out_b), .OUT_VALID(vld_b), .PRIMED(prm_b));

  moving_avg_filter #(.DATA_W(24), .LOG2_N(0), .ROUND(1), .EARLY_OUT(0)) dut_c (
    .CLK(CLK), .RST(RST), .IN(IN), .IN_VALID(IN_VALID), .CLEAR(CLEAR),
    .OUT(out_c), .OUT_VALID(vld_c), .PRIMED(prm_c));

  task automatic cmp(input string nm, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  // One accepted sample; va/vb say whether dut_a/dut_b must emit ea/eb.
  task automatic send(input logic [23:0] s, input bit va, input logic [23:0] ea,
                      input bit vb, input logic [23:0] eb);
    @(posedge CLK); #1;
    IN = s; IN_VALID = 1'b1; CLEAR = 1'b0;
    if (va) q_a.push_back(ea);
    if (vb) q_b.push_back(eb);
    q_c.push_back(s);
  endtask

  task automatic idle();
    @(posedge CLK); #1;
    IN_VALID = 1'b0; CLEAR = 1'b0;
  endtask

  task automatic chk_primed(input string nm, input logic exp);
    cmp({nm, "_a"}, {23'b0, prm_a}, {23'b0, exp});
    cmp({nm, "_b"}, {23'b0, prm_b}, {23'b0, exp});
  endtask

  // Monitor: scoreboard pop on OUT_VALID, hold check otherwise.
  initial begin : monitor
    logic [23:0] last_a, last_b, last_c;
    last_a = '0; last_b = '0; last_c = '0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (vld_a) begin
          if (q_a.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL a_spurious_valid: got OUT_VALID with %h, expected none", out_a);
          end else cmp("a_out", out_a, q_a.pop_front());
        end else if (out_a !== last_a) cmp("a_hold", out_a, last_a);
        if (vld_b) begin
          if (q_b.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL b_spurious_valid: got OUT_VALID with %h, expected none", out_b);
          end else cmp("b_out", out_b, q_b.pop_front());
        end else if (out_b !== last_b) cmp("b_hold", out_b, last_b);
        if (vld_c) begin
          if (q_c.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL c_spurious_valid: got OUT_VALID with %h, expected none", out_c);
          end else cmp("c_out", out_c, q_c.pop_front());
        end else if (out_c !== last_c) cmp("c_hold", out_c, last_c);
      end
      last_a = out_a; last_b = out_b; last_c = out_c;
    end
  end

  initial begin : stimulus
    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    cmp("rst_out_a", out_a, 24'h0);
    cmp("rst_out_b", out_b, 24'h0);
    cmp("rst_vld_a", {23'b0, vld_a}, 24'h0);
    chk_primed("rst_primed", 1'b0);
    RST = 1'b0;

    // Step: four samples of 100
    send(24'd100, 0, 24'd0,   1, 24'd25);
    send(24'd100, 0, 24'd0,   1, 24'd50);
    send(24'd100, 0, 24'd0,   1, 24'd75);
    idle();
    chk_primed("step_primed3", 1'b0);
    send(24'd100, 1, 24'd100, 1, 24'd100);
    idle();
    chk_primed("step_primed4", 1'b1);

    // Flush window to zeros, then impulse of 400
    send(24'd0,   1, 24'd75,  1, 24'd75);
    send(24'd0,   1, 24'd50,  1, 24'd50);
    send(24'd0,   1, 24'd25,  1, 24'd25);
    send(24'd0,   1, 24'd0,   1, 24'd0);
    send(24'd400, 1, 24'd100, 1, 24'd100);
    send(24'd0,   1, 24'd100, 1, 24'd100);
    send(24'd0,   1, 24'd100, 1, 24'd100);
    send(24'd0,   1, 24'd100, 1, 24'd100);
    send(24'd0,   1, 24'd0,   1, 24'd0);

    // Rounding: window 1,1,0,0 then -1,0,0,0
    send(24'd1,      1, 24'd0, 1, 24'd0);
    send(24'd1,      1, 24'd1, 1, 24'd0);
    send(24'd0,      1, 24'd1, 1, 24'd0);
    send(24'd0,      1, 24'd1, 1, 24'd0);
    send(24'hFFFFFF, 1, 24'd0, 1, 24'd0);
    send(24'd0,      1, 24'd0, 1, 24'hFFFFFF);
    send(24'd0,      1, 24'd0, 1, 24'hFFFFFF);
    send(24'd0,      1, 24'd0, 1, 24'hFFFFFF);

    // Extremes: most positive then most negative
    send(24'h7FFFFF, 1, 24'h200000, 1, 24'h1FFFFF);
    send(24'h7FFFFF, 1, 24'h400000, 1, 24'h3FFFFF);
    send(24'h7FFFFF, 1, 24'h5FFFFF, 1, 24'h5FFFFF);
    send(24'h7FFFFF, 1, 24'h7FFFFF, 1, 24'h7FFFFF);
    send(24'h800000, 1, 24'h3FFFFF, 1, 24'h3FFFFF);
    send(24'h800000, 1, 24'h000000, 1, 24'hFFFFFF);
    send(24'h800000, 1, 24'hC00000, 1, 24'hBFFFFF);
    send(24'h800000, 1, 24'h800000, 1, 24'h800000);
    idle();

    // CLEAR together with IN_VALID while running: sample dropped
    @(posedge CLK); #1;
    IN = 24'd999; IN_VALID = 1'b1; CLEAR = 1'b1;
    idle();
    chk_primed("clear_primed", 1'b0);
    send(24'd8, 0, 24'd0, 1, 24'd2);
    send(24'd8, 0, 24'd0, 1, 24'd4);
    send(24'd8, 0, 24'd0, 1, 24'd6);
    send(24'd8, 1, 24'd8, 1, 24'd8);
    idle();
    chk_primed("clear_refill_primed", 1'b1);

    // Gaps: IN_VALID every other cycle across pointer wrap
    send(24'd10,  1, 24'd9,   1, 24'd8);   idle();
    send(24'd20,  1, 24'd12,  1, 24'd11);  idle();
    send(24'd30,  1, 24'd17,  1, 24'd17);  idle();
    send(24'd40,  1, 24'd25,  1, 24'd25);  idle();
    send(24'd50,  1, 24'd35,  1, 24'd35);  idle();
    send(24'd60,  1, 24'd45,  1, 24'd45);  idle();
    send(24'd70,  1, 24'd55,  1, 24'd55);  idle();
    send(24'd80,  1, 24'd65,  1, 24'd65);  idle();
    send(24'd90,  1, 24'd75,  1, 24'd75);  idle();
    send(24'd100, 1, 24'd85,  1, 24'd85);  idle();
    send(24'd110, 1, 24'd95,  1, 24'd95);  idle();
    send(24'd120, 1, 24'd105, 1, 24'd105); idle();

    // RST in the middle of a running window
    send(24'd5, 1, 24'd84, 1, 24'd83);
    send(24'd5, 1, 24'd60, 1, 24'd60);
    idle();
    idle();
    RST = 1'b1;
    #1;
    cmp("rst_mid_out_a", out_a, 24'h0);
    cmp("rst_mid_out_b", out_b, 24'h0);
    cmp("rst_mid_vld_a", {23'b0, vld_a}, 24'h0);
    chk_primed("rst_mid_primed", 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    send(24'd8, 0, 24'd0, 1, 24'd2);
    send(24'd8, 0, 24'd0, 1, 24'd4);
    send(24'd8, 0, 24'd0, 1, 24'd6);
    send(24'd8, 1, 24'd8, 1, 24'd8);
    idle();
    chk_primed("rst_refill_primed", 1'b1);

    // Every expected result must have been produced
    repeat (4) idle();
    cmp("a_left", 24'(q_a.size()), 24'd0);
    cmp("b_left", 24'(q_b.size()), 24'd0);
    cmp("c_left", 24'(q_c.size()), 24'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
